// File: rtl/interval_timer_bank_if.sv
// Start/expired handshake and table-programming bundle between a traffic controller and interval_timer_bank.
// The hold signal exists only when TIMER_PAUSE_EN is defined.
interface interval_timer_bank_if #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 4
);
    logic             start_timer;
    logic [SEL_W-1:0] interval_selector;
    logic             reprogram;
    logic [SEL_W-1:0] prog_index;
    logic [CNT_W-1:0] prog_value;
`ifdef TIMER_PAUSE_EN
    logic             hold;
`endif
    logic             expired;
    logic             busy;
    logic [CNT_W-1:0] time_remaining;

    modport master (
        output start_timer, interval_selector, reprogram, prog_index, prog_value,
`ifdef TIMER_PAUSE_EN
        output hold,
`endif
        input  expired, busy, time_remaining
    );

    modport slave (
        input  start_timer, interval_selector, reprogram, prog_index, prog_value,
`ifdef TIMER_PAUSE_EN
        input  hold,
`endif
        output expired, busy, time_remaining
    );
endinterface

// File: rtl/interval_timer_bank.sv
// Interval timer bank: reprogrammable table counted down in TICK_DIV-cycle ticks; TIMER_PAUSE_EN adds hold.
// All outputs registered, busy/value visible one edge after start; no backpressure, every valid request is taken.
module interval_timer_bank #(
    parameter int                              NUM_INTERVALS = 4,
    parameter int                              CNT_W         = 4,
    parameter int                              TICK_DIV      = 50000000,
    parameter logic [NUM_INTERVALS*CNT_W-1:0]  INIT_TABLE    = 16'h2363
) (
    input  logic                 clk,
    input  logic                 reset,
    interval_timer_bank_if.slave tmr
);
    localparam int SEL_W = (NUM_INTERVALS > 1) ? $clog2(NUM_INTERVALS) : 1;
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tr_q, tr_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             exp_q, exp_d;
    logic             zero_pend_q, zero_pend_d;
    logic [CNT_W-1:0] tbl_q [NUM_INTERVALS];
    logic [CNT_W-1:0] tbl_d [NUM_INTERVALS];

    logic             held;
    logic             sel_ok;
    logic [CNT_W-1:0] sel_val;
    logic             start_ok;
    logic             tick;
    logic             finish;

`ifdef TIMER_PAUSE_EN
    assign held = tmr.hold;
`else
    assign held = 1'b0;
`endif

    // Table lookup and write decode; out-of-range indices match no entry and so are ignored.
    always_comb begin
        sel_ok  = 1'b0;
        sel_val = '0;
        for (int i = 0; i < NUM_INTERVALS; i++) begin
            tbl_d[i] = tbl_q[i];
            if (tmr.interval_selector == SEL_W'(i)) begin
                sel_ok  = 1'b1;
                sel_val = tbl_q[i];
            end
            if (tmr.reprogram && (tmr.prog_index == SEL_W'(i))) begin
                tbl_d[i] = tmr.prog_value;
            end
        end
    end

    assign start_ok = tmr.start_timer && sel_ok;
    assign tick     = (state_q == RUN) && !held && (ps_q == PS_MAX);
    assign finish   = tick && (tr_q == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_ok) begin
            state_d = (sel_val != '0) ? RUN : IDLE;
        end else if (finish) begin
            state_d = IDLE;
        end
    end

    // A start wins over a finishing countdown, but the finished interval still reports expiry.
    always_comb begin
        tr_d        = tr_q;
        ps_d        = ps_q;
        exp_d       = zero_pend_q || finish;
        zero_pend_d = 1'b0;
        if ((state_q == RUN) && !held) begin
            ps_d = tick ? '0 : ps_q + PS_W'(1);
        end
        if (start_ok) begin
            tr_d        = sel_val;
            ps_d        = '0;
            zero_pend_d = (sel_val == '0);
        end else if (tick) begin
            tr_d = tr_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tr_q        <= '0;
            ps_q        <= '0;
            exp_q       <= 1'b0;
            zero_pend_q <= 1'b0;
            for (int i = 0; i < NUM_INTERVALS; i++) begin
                tbl_q[i] <= INIT_TABLE[i*CNT_W +: CNT_W];
            end
        end else begin
            tr_q        <= tr_d;
            ps_q        <= ps_d;
            exp_q       <= exp_d;
            zero_pend_q <= zero_pend_d;
            for (int i = 0; i < NUM_INTERVALS; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    assign tmr.expired        = exp_q;
    assign tmr.busy           = (state_q == RUN);
    assign tmr.time_remaining = tr_q;
endmodule
